// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter (IF fetch vs. ID data port).
// Build option DMEM_ARB_RR_EN switches winner selection to round-robin.
package dmem_port_arbiter_pkg;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned DATA_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    // OWN_DATA is the all-zero encoding so the reset owner falls out of '0.
    typedef enum logic {
        OWN_DATA = 1'b0,
        OWN_IF   = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        LEN_B = 2'd0,
        LEN_H = 2'd1,
        LEN_W = 2'd2,
        LEN_D = 2'd3
    } len_e;

    typedef struct packed {
        owner_e              owner;
        logic                wen;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   wdata;
        len_e                wlen;
    } mem_req_t;

    function automatic mem_req_t fetch_req(input logic [ADDR_W-1:0] addr);
        mem_req_t r;
        r.owner = OWN_IF;
        r.wen   = 1'b0;
        r.addr  = addr;
        r.wdata = '0;
        r.wlen  = LEN_W;
        return r;
    endfunction

    function automatic mem_req_t data_req(input logic              wen,
                                          input logic [ADDR_W-1:0] addr,
                                          input logic [DATA_W-1:0] wdata,
                                          input logic [1:0]        wlen);
        mem_req_t r;
        r.owner = OWN_DATA;
        r.wen   = wen;
        r.addr  = addr;
        r.wdata = wdata;
        r.wlen  = len_e'(wlen);
        return r;
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection between IF and data requesters.
// DMEM_ARB_RR_EN: round-robin on contention; otherwise data priority with starvation guard.
module dmem_arb_pick
    import dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned CNT_W        = 4
) (
    input  logic             if_valid_i,
    input  logic             d_valid_i,
`ifdef DMEM_ARB_RR_EN
    input  owner_e           last_grant_i,
`else
    input  logic [CNT_W-1:0] starve_cnt_i,
`endif
    output logic             grant_if_o,
    output logic             grant_d_o
);

`ifdef DMEM_ARB_RR_EN
    always_comb begin
        grant_if_o = 1'b0;
        grant_d_o  = 1'b0;
        if (if_valid_i && d_valid_i) begin
            if (last_grant_i == OWN_DATA) begin
                grant_if_o = 1'b1;
            end else begin
                grant_d_o = 1'b1;
            end
        end else begin
            grant_if_o = if_valid_i;
            grant_d_o  = d_valid_i;
        end
    end
`else
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    always_comb begin
        grant_if_o = 1'b0;
        grant_d_o  = 1'b0;
        if (if_valid_i && d_valid_i) begin
            if (starve_cnt_i >= LIMIT) begin
                grant_if_o = 1'b1;
            end else begin
                grant_d_o = 1'b1;
            end
        end else begin
            grant_if_o = if_valid_i;
            grant_d_o  = d_valid_i;
        end
    end
`endif

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one memory request port between IF and the ID data port, one transaction in flight.
// DMEM_ARB_RR_EN selects round-robin arbitration instead of data priority + starvation guard.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned CNT_W        = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    output logic              if_resp_valid,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req_valid,
    input  logic              d_req_wen,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    input  logic [1:0]        d_req_wlen,
    output logic              d_req_ready,
    output logic              d_resp_valid,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_wlen,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e   state_q, state_d;
    mem_req_t req_q, req_d;
    logic     grant_if, grant_d;

`ifdef DMEM_ARB_RR_EN
    // Reset to OWN_IF so the first contended grant goes to DATA.
    owner_e last_grant_q, last_grant_d;
`else
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
`endif

    dmem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_pick (
        .if_valid_i   (if_req_valid),
        .d_valid_i    (d_req_valid),
`ifdef DMEM_ARB_RR_EN
        .last_grant_i (last_grant_q),
`else
        .starve_cnt_i (starve_cnt_q),
`endif
        .grant_if_o   (grant_if),
        .grant_d_o    (grant_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            req_q        <= '0;
`ifdef DMEM_ARB_RR_EN
            last_grant_q <= OWN_IF;
`else
            starve_cnt_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
`ifdef DMEM_ARB_RR_EN
            last_grant_q <= last_grant_d;
`else
            starve_cnt_q <= starve_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        unique case (state_q)
            IDLE: begin
                if (grant_if) begin
                    req_d   = fetch_req(if_req_addr);
                    state_d = REQ;
                end else if (grant_d) begin
                    req_d   = data_req(d_req_wen, d_req_addr, d_req_wdata, d_req_wlen);
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (mem_resp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef DMEM_ARB_RR_EN
    always_comb begin
        last_grant_d = last_grant_q;
        if (if_req_ready) begin
            last_grant_d = OWN_IF;
        end else if (d_req_ready) begin
            last_grant_d = OWN_DATA;
        end
    end
`else
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req_valid || if_req_ready) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != '1) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end
`endif

    // Handshake outputs are held low while rst is asserted so nothing is
    // acknowledged in a cycle whose state update is about to be discarded.
    always_comb begin
        if_req_ready  = 1'b0;
        d_req_ready   = 1'b0;
        if_resp_valid = 1'b0;
        d_resp_valid  = 1'b0;
        if_rdata      = '0;
        d_rdata       = '0;
        mem_req_valid = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if_req_ready = grant_if;
                    d_req_ready  = grant_d;
                end
                REQ: begin
                    mem_req_valid = 1'b1;
                end
                RESP: begin
                    if (mem_resp_valid) begin
                        if (req_q.owner == OWN_IF) begin
                            if_resp_valid = 1'b1;
                            if_rdata      = mem_rdata;
                        end else begin
                            d_resp_valid = 1'b1;
                            d_rdata      = mem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_wen   = req_q.wen;
    assign mem_addr  = req_q.addr;
    assign mem_wdata = req_q.wdata;
    assign mem_wlen  = req_q.wlen;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter (default build, data priority + starvation guard).
module tb_dmem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req_valid;
    logic [63:0] if_req_addr;
    logic        if_req_ready;
    logic        if_resp_valid;
    logic [63:0] if_rdata;
    logic        d_req_valid;
    logic        d_req_wen;
    logic [63:0] d_req_addr;
    logic [63:0] d_req_wdata;
    logic [1:0]  d_req_wlen;
    logic        d_req_ready;
    logic        d_resp_valid;
    logic [63:0] d_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_wen;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [1:0]  mem_wlen;
    logic        mem_resp_valid;
    logic [63:0] mem_rdata;

    int checks;
    int failures;

    dmem_port_arbiter #(
        .STARVE_LIMIT (8),
        .CNT_W        (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_req_valid   (if_req_valid),
        .if_req_addr    (if_req_addr),
        .if_req_ready   (if_req_ready),
        .if_resp_valid  (if_resp_valid),
        .if_rdata       (if_rdata),
        .d_req_valid    (d_req_valid),
        .d_req_wen      (d_req_wen),
        .d_req_addr     (d_req_addr),
        .d_req_wdata    (d_req_wdata),
        .d_req_wlen     (d_req_wlen),
        .d_req_ready    (d_req_ready),
        .d_resp_valid   (d_resp_valid),
        .d_rdata        (d_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_wen        (mem_wen),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wlen       (mem_wlen),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // reference model state for the random phase
        bit          m_busy, m_taken, m_own_if, m_wen;
        logic [63:0] m_addr, m_wdata;
        logic [1:0]  m_wlen;
        int unsigned m_wait;
        bit          e_if_rdy, e_d_rdy, e_req, e_resp, if_acc, d_acc;

        checks = 0;
        failures = 0;
        rst = 1'b1;
        if_req_valid = 1'b0; if_req_addr = '0;
        d_req_valid = 1'b0; d_req_wen = 1'b0; d_req_addr = '0; d_req_wdata = '0; d_req_wlen = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;

        // Reset state
        @(negedge clk); @(negedge clk);
        #1;
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_wen", mem_wen, 0);
        chk("rst_mem_wlen", mem_wlen, 0);
        chk("rst_if_ready", if_req_ready, 0);
        chk("rst_d_ready", d_req_ready, 0);
        chk("rst_resp", {if_resp_valid, d_resp_valid}, 0);
        @(negedge clk); rst = 1'b0;

        // Data load, minimum latency
        @(negedge clk);
        d_req_valid = 1'b1; d_req_wen = 1'b0; d_req_addr = 64'h8000_1000; d_req_wlen = 2'd3;
        #1;
        chk("load_d_ready", d_req_ready, 1);
        chk("load_if_ready", if_req_ready, 0);
        @(negedge clk);
        d_req_valid = 1'b0; mem_req_ready = 1'b1;
        #1;
        chk("load_mem_req_valid", mem_req_valid, 1);
        chk("load_mem_addr", mem_addr, 64'h8000_1000);
        chk("load_mem_wlen", mem_wlen, 3);
        chk("load_mem_wen", mem_wen, 0);
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1;
        chk("load_resp_wait_req", mem_req_valid, 0);
        chk("load_resp_wait_d", d_resp_valid, 0);
        @(negedge clk);
        mem_resp_valid = 1'b1; mem_rdata = 64'h1122_3344_5566_7788;
        #1;
        chk("load_d_resp", d_resp_valid, 1);
        chk("load_d_rdata", d_rdata, 64'h1122_3344_5566_7788);
        chk("load_if_resp", if_resp_valid, 0);

        // Simultaneous IF and store: data first, IF right after the store response
        @(negedge clk);
        mem_resp_valid = 1'b0;
        if_req_valid = 1'b1; if_req_addr = 64'h0000_1000;
        d_req_valid = 1'b1; d_req_wen = 1'b1; d_req_addr = 64'h0000_2000; d_req_wdata = 64'hAB; d_req_wlen = 2'd0;
        #1;
        chk("both_d_ready", d_req_ready, 1);
        chk("both_if_ready", if_req_ready, 0);
        @(negedge clk);
        d_req_valid = 1'b0; mem_req_ready = 1'b1;
        #1;
        chk("st_mem_wen", mem_wen, 1);
        chk("st_mem_wlen", mem_wlen, 0);
        chk("st_mem_wdata", mem_wdata, 64'hAB);
        chk("st_mem_addr", mem_addr, 64'h2000);
        @(negedge clk);
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 64'hDEAD;
        #1;
        chk("st_d_resp", d_resp_valid, 1);
        chk("st_if_ready_busy", if_req_ready, 0);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        chk("if_after_st_ready", if_req_ready, 1);
        @(negedge clk);
        if_req_valid = 1'b0; mem_req_ready = 1'b1;
        #1;
        chk("if_mem_wen", mem_wen, 0);
        chk("if_mem_wlen", mem_wlen, 2);
        chk("if_mem_wdata", mem_wdata, 0);
        chk("if_mem_addr", mem_addr, 64'h1000);
        @(negedge clk);
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 64'h0000_0000_0013_0001;
        #1;
        chk("if_resp", if_resp_valid, 1);
        chk("if_rdata", if_rdata, 64'h0000_0000_0013_0001);
        chk("if_resp_d", d_resp_valid, 0);

        // Starvation: 3-cycle transactions, IF wins at the IDLE where it has waited >= 8
        @(negedge clk);
        mem_resp_valid = 1'b1; mem_req_ready = 1'b1; mem_rdata = 64'h55;
        if_req_valid = 1'b1; if_req_addr = 64'h0000_3000;
        d_req_valid = 1'b1; d_req_wen = 1'b0; d_req_addr = 64'h0000_4000; d_req_wlen = 2'd2;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("starve_if_ready", if_req_ready, (i == 9));
            chk("starve_d_ready", d_req_ready, (i % 3 == 0) && (i < 9));
            chk("starve_d_resp", d_resp_valid, (i % 3 == 2));
            @(negedge clk);
        end
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        #1;
        chk("starve_if_addr", mem_addr, 64'h3000);
        chk("starve_same_cycle_resp", if_resp_valid, 0);
        @(negedge clk);
        #1;
        chk("starve_if_resp", if_resp_valid, 1);
        @(negedge clk);
        mem_resp_valid = 1'b0; mem_req_ready = 1'b0;

        // Reset in RESP abandons the transaction
        @(negedge clk);
        d_req_valid = 1'b1; d_req_addr = 64'h0000_5000;
        #1;
        chk("rr_accept", d_req_ready, 1);
        @(negedge clk);
        d_req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 64'hBAD;
        #1;
        chk("rst_resp_pulse", {if_resp_valid, d_resp_valid}, 0);
        chk("rst_resp_rdata", d_rdata | if_rdata, 0);
        chk("rst_resp_req_valid", mem_req_valid, 0);
        chk("rst_resp_addr", mem_addr, 0);
        chk("rst_resp_fields", {mem_wen, mem_wlen, mem_wdata}, 0);
        @(negedge clk);
        mem_resp_valid = 1'b0;

        // Backpressure: request held stable, no new accept
        @(negedge clk);
        d_req_valid = 1'b1; d_req_wen = 1'b1; d_req_addr = 64'h0000_6000; d_req_wdata = 64'h5555; d_req_wlen = 2'd1;
        if_req_valid = 1'b1; if_req_addr = 64'h0000_7000;
        #1;
        chk("bp_accept", d_req_ready, 1);
        @(negedge clk);
        d_req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_req_valid", mem_req_valid, 1);
            chk("bp_addr", mem_addr, 64'h6000);
            chk("bp_wdata", mem_wdata, 64'h5555);
            chk("bp_no_accept", if_req_ready, 0);
            @(negedge clk);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1;
        #1;
        chk("bp_d_resp", d_resp_valid, 1);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        #1;
        chk("bp_if_ready", if_req_ready, 1);
        @(negedge clk);
        if_req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 64'h77;
        #1;
        chk("bp_if_resp", if_resp_valid, 1);
        @(negedge clk);
        mem_resp_valid = 1'b0;
        @(negedge clk);

        // Random traffic against a transaction-level model
        m_busy = 0; m_taken = 0; m_own_if = 0; m_wen = 0;
        m_addr = '0; m_wdata = '0; m_wlen = '0; m_wait = 0;
        if_acc = 0; d_acc = 0;
        for (int c = 0; c < 3000; c++) begin
            if (if_acc) if_req_valid = 1'b0;
            if (d_acc) d_req_valid = 1'b0;
            if (!if_req_valid && $urandom_range(1, 0) == 1) begin
                if_req_valid = 1'b1;
                if_req_addr = {$urandom, $urandom};
            end else if (if_req_valid && $urandom_range(15, 0) == 0) begin
                if_req_valid = 1'b0;
            end
            if (!d_req_valid && $urandom_range(3, 0) != 0) begin
                d_req_valid = 1'b1;
                d_req_wen = 1'($urandom_range(1, 0));
                d_req_addr = {$urandom, $urandom};
                d_req_wdata = {$urandom, $urandom};
                d_req_wlen = 2'($urandom_range(3, 0));
            end else if (d_req_valid && $urandom_range(31, 0) == 0) begin
                d_req_valid = 1'b0;
            end
            mem_req_ready = 1'($urandom_range(1, 0));
            mem_resp_valid = (m_busy && m_taken) ? ($urandom_range(2, 0) == 0) : ($urandom_range(7, 0) == 0);
            mem_rdata = {$urandom, $urandom};
            #1;
            e_if_rdy = !m_busy && if_req_valid && (!d_req_valid || m_wait >= 8);
            e_d_rdy  = !m_busy && d_req_valid && !e_if_rdy;
            e_req    = m_busy && !m_taken;
            e_resp   = m_busy && m_taken && mem_resp_valid;
            chk("rnd_if_ready", if_req_ready, e_if_rdy);
            chk("rnd_d_ready", d_req_ready, e_d_rdy);
            chk("rnd_mem_req_valid", mem_req_valid, e_req);
            if (e_req) begin
                chk("rnd_mem_addr", mem_addr, m_addr);
                chk("rnd_mem_wdata", mem_wdata, m_wdata);
                chk("rnd_mem_ctl", {mem_wen, mem_wlen}, {m_wen, m_wlen});
            end
            chk("rnd_if_resp", if_resp_valid, e_resp && m_own_if);
            chk("rnd_d_resp", d_resp_valid, e_resp && !m_own_if);
            if (e_resp) begin
                chk("rnd_rdata", m_own_if ? if_rdata : d_rdata, mem_rdata);
            end
            if (e_resp) m_busy = 0;
            else if (e_req && mem_req_ready) m_taken = 1;
            if (e_if_rdy) begin
                m_busy = 1; m_taken = 0; m_own_if = 1;
                m_addr = if_req_addr; m_wdata = '0; m_wen = 0; m_wlen = 2'd2;
            end else if (e_d_rdy) begin
                m_busy = 1; m_taken = 0; m_own_if = 0;
                m_addr = d_req_addr; m_wdata = d_req_wdata; m_wen = d_req_wen; m_wlen = d_req_wlen;
            end
            m_wait = (if_req_valid && !e_if_rdy) ? ((m_wait < 15) ? m_wait + 1 : 15) : 0;
            if_acc = e_if_rdy;
            d_acc = e_d_rdy;
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Shares the single memory request port between instruction fetch (IF) and the ID-stage data port (loads/stores).
- One transaction outstanding at a time.
- Data requests have priority by default; a starvation counter guarantees IF progress.
- Sits between IF/ID and the memory bus; owns the req/ready/resp handshake and latches request fields.

Parameters:
STARVE_LIMIT, 8, consecutive cycles IF may wait with a pending request before it is forced to win the next arbitration.
CNT_W, 4, width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
if_req_valid  in  1  IF read request
if_req_addr  in  64  fetch address
if_req_ready  out  1  IF request accepted this cycle
if_resp_valid  out  1  fetch data valid
if_rdata  out  64  fetch data (low 32 bits = instruction)
d_req_valid  in  1  ID data request (load or store)
d_req_wen  in  1  1 = store
d_req_addr  in  64  data address
d_req_wdata  in  64  store data, already zero-extended
d_req_wlen  in  2  0 = byte, 1 = half, 2 = word, 3 = double
d_req_ready  out  1  data request accepted this cycle
d_resp_valid  out  1  load data valid, or store complete
d_rdata  out  64  load data (raw; extension done downstream)
mem_req_valid  out  1  bus request
mem_req_ready  in  1  bus accepts request
mem_wen  out  1  bus write enable
mem_addr  out  64  bus address
mem_wdata  out  64  bus write data
mem_wlen  out  2  bus access size
mem_resp_valid  in  1  bus response
mem_rdata  in  64  bus read data

Behaviour:
Reset and clock:
- Single clock `clk`.
- `rst` is synchronous and active-high.
- On reset, all outputs are 0, state = IDLE, owner = DATA, starve_cnt = 0, latched fields = 0.

States:
- IDLE
  - Arbitrate and accept.
  - `if_req_ready` / `d_req_ready` are combinational: asserted only in IDLE, for the winner.
  - On accept, latch addr/wen/wdata/wlen and owner, then go to REQ.
  - For IF: wen = 0, wlen = 2, wdata = 0.
- REQ
  - `mem_req_valid` = 1; `mem_*` are driven from the latched fields and held stable.
  - On `mem_req_ready` go to RESP.
- RESP
  - `mem_req_valid` = 0.
  - When `mem_resp_valid` = 1, pulse the owner's `*_resp_valid` combinationally, with `*_rdata` = `mem_rdata`, then go to IDLE.
  - The non-owner's `resp_valid` stays 0.

Arbitration (IDLE only):
- Only one requester valid: it wins.
- Both valid: DATA wins unless starve_cnt >= STARVE_LIMIT, in which case IF wins.
- starve_cnt increments (saturating) each cycle `if_req_valid` = 1 and IF is not accepted.
- starve_cnt clears when IF is accepted or `if_req_valid` = 0.

Timing:
- Minimum latency is accept at cycle N, `mem_req_valid` at N+1, response same cycle as `mem_resp_valid`.
- The next accept is possible in the cycle after the response (IDLE).
- Stores complete on `mem_resp_valid`; `mem_rdata` is ignored for stores but still passed through.

Rules and boundaries:
- Requesters hold valid and fields until ready; dropping valid before ready is legal and simply withdraws the request.
- `mem_resp_valid` while in IDLE or REQ is ignored.
- `rst` asserted mid-transaction abandons it. A later stray `mem_resp_valid` is ignored because state is IDLE.
- `mem_req_ready` and `mem_resp_valid` in the same cycle while in REQ: only the ready is consumed; the response is expected in a later cycle.
- starve_cnt saturates at 2^CNT_W - 1.

Optional Feature:
DMEM_ARB_RR_EN
- Defined: round-robin. When both requesters are valid, the one not granted last wins. starve_cnt logic is removed and STARVE_LIMIT is unused.
- Undefined: data-priority with the starvation guard described above.

Decomposition:
Shared package holds:
- State encoding: IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2.
- Owner encoding: OWN_IF / OWN_DATA.
- wlen constants: LEN_B / H / W / D = 0..3.
- Bus widths: 64-bit addr/data.

Sub-module: `dmem_arb_pick`, the combinational winner selection (priority + starvation, or RR under the macro), which is unit-testable standalone. The FSM, latches and counter stay in the top module.

Test Plan:
- Data load only: d_req_valid = 1, addr = 0x80001000, wlen = 3; mem_req_ready at N+1, mem_resp_valid at N+3 with rdata = 0x1122334455667788 -> d_req_ready at N, mem_addr = 0x80001000 from N+1, d_resp_valid at N+3 with rdata = 0x1122334455667788, if_resp_valid = 0.
- Simultaneous IF and store (wdata = 0xAB, wlen = 0) in IDLE -> data granted first with mem_wen = 1, mem_wlen = 0; IF granted in the IDLE cycle after the store response, with mem_wlen = 2, mem_wen = 0.
- Starvation, macro off: d_req_valid held high continuously with single-cycle bus latency, if_req_valid held high -> IF accepted once starve_cnt reaches 8; starve_cnt = 0 the cycle after.
- Reset in RESP: rst = 1 for one cycle, then mem_resp_valid = 1 -> no resp_valid pulse; all outputs 0; state IDLE.
- Backpressure: mem_req_ready = 0 for 5 cycles -> mem_req_valid, mem_addr and mem_wdata stable for all 5 cycles; no new accept.
- Macro on: both valid for 4 back-to-back transactions -> grants alternate DATA, IF, DATA, IF.
